// File: rtl/pixel_reconstruct_pkg.sv
// pixel_reconstruct_pkg: shared widths, FSM states and pixel bundle for the camera front-end.
package pixel_reconstruct_pkg;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int PIXEL_W  = 16;

    typedef enum logic [1:0] {WAIT_VS, WAIT_LINE, HIGH_BYTE, LOW_BYTE} state_e;

    typedef struct packed {
        logic                valid;
        logic [PIXEL_W-1:0]  data;
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
    } pixel_t;
endpackage

// File: rtl/pixel_reconstruct_edge_detect.sv
// pixel_reconstruct_edge_detect: registered previous copy of a sampled level and its rising or falling edge.
module pixel_reconstruct_edge_detect #(
    parameter bit RISE = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic edge_out
);
    logic prev_q;

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) prev_q <= 1'b0;
        else         prev_q <= sig_in;

    assign edge_out = RISE ? (sig_in & ~prev_q) : (~sig_in & prev_q);
endmodule

// File: rtl/pixel_reconstruct.sv
// pixel_reconstruct: rebuilds RGB565 pixels from an 8-bit camera bus and tags them with column/row.
module pixel_reconstruct
    import pixel_reconstruct_pkg::*;
#(
    parameter int unsigned HRES = 1280,
    parameter int unsigned VRES = 720
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                camera_pclk_in,
    input  logic                camera_hs_in,
    input  logic                camera_vs_in,
    input  logic [7:0]          camera_data_in,
    output logic                data_valid_out,
    output logic [PIXEL_W-1:0]  pixel_data_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                frame_start_out,
    output logic                line_error_out
);
    state_e              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [HCOUNT_W-1:0] hcount_q, hcount_d;
    logic [VCOUNT_W-1:0] vcount_q, vcount_d;
    pixel_t              pix_q, pix_d;
    logic                fs_q, fs_d, err_q, err_d;
    logic                pclk_rise, hs_fall, vs_fall;
    logic                live, accept, line_end, emit, in_range;

    pixel_reconstruct_edge_detect #(.RISE(1'b1)) u_pclk (
        .clk_in(clk_in), .rst_in(rst_in), .sig_in(camera_pclk_in), .edge_out(pclk_rise));
    pixel_reconstruct_edge_detect #(.RISE(1'b0)) u_hs (
        .clk_in(clk_in), .rst_in(rst_in), .sig_in(camera_hs_in), .edge_out(hs_fall));
    pixel_reconstruct_edge_detect #(.RISE(1'b0)) u_vs (
        .clk_in(clk_in), .rst_in(rst_in), .sig_in(camera_vs_in), .edge_out(vs_fall));

    // A VSYNC fall masks any line end or byte landing in the same cycle.
    assign live     = state_q != WAIT_VS && !vs_fall;
    assign accept   = live && pclk_rise && camera_hs_in && !camera_vs_in;
    assign line_end = live && hs_fall && (state_q == HIGH_BYTE || state_q == LOW_BYTE);
    assign emit     = accept && state_q == LOW_BYTE;
    assign in_range = 32'(hcount_q) < HRES && 32'(vcount_q) < VRES;

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            state_q  <= WAIT_VS;
            hi_q     <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            pix_q    <= '0;
            fs_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            pix_q    <= pix_d;
            fs_q     <= fs_d;
            err_q    <= err_d;
        end

    always_comb begin
        state_d = state_q;
        if (vs_fall || line_end) state_d = WAIT_LINE;
        else if (accept)         state_d = state_q == LOW_BYTE ? HIGH_BYTE : LOW_BYTE;
    end

    // Clipped pixels still advance hcount but leave the last visible pixel on the outputs.
    always_comb begin
        hi_d        = accept && state_q != LOW_BYTE ? camera_data_in : hi_q;
        hcount_d    = vs_fall || line_end ? '0
                    : emit && !(&hcount_q) ? hcount_q + HCOUNT_W'(1) : hcount_q;
        vcount_d    = vs_fall ? '0
                    : line_end && !(&vcount_q) ? vcount_q + VCOUNT_W'(1) : vcount_q;
        pix_d       = pix_q;
        pix_d.valid = emit && in_range;
        if (pix_d.valid) begin
            pix_d.data   = {hi_q, camera_data_in};
            pix_d.hcount = hcount_q;
            pix_d.vcount = vcount_q;
        end
        fs_d  = vs_fall;
        err_d = line_end && state_q == LOW_BYTE;
    end

    assign data_valid_out  = pix_q.valid;
    assign pixel_data_out  = pix_q.data;
    assign hcount_out      = pix_q.hcount;
    assign vcount_out      = pix_q.vcount;
    assign frame_start_out = fs_q;
    assign line_error_out  = err_q;
endmodule
